ethernet_tx_buffer: RTL

- TX-side responder for the Ethernet MMIO control unit. It sinks that unit's packet write, size, send and TX-interrupt signals.
- Stores one outgoing frame (single slot) in byte-addressed buffer RAM, then streams it byte-wise on an AXI-Stream master port toward the MAC.
- Maintains the TX event-pending/enable state that the control unit reads back at 0x1030.

---
 rtl/ethernet_tx_buffer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ethernet_tx_buffer.sv
// Single-slot Ethernet TX frame buffer: MMIO-side byte writes into RAM, then byte-wise
// AXI-Stream playback toward the MAC with a TX-done pending/enable interrupt.
module ethernet_tx_buffer #(
  parameter int unsigned eth_mtu_p    = 2048,
  parameter int unsigned data_width_p = 32,
  localparam int unsigned size_width_lp        = $clog2(data_width_p / 8),
  localparam int unsigned packet_size_width_lp = $clog2(eth_mtu_p + 1),
  localparam int unsigned packet_addr_width_lp = $clog2(eth_mtu_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            packet_send_i,
  output logic                            packet_req_o,
  input  logic                            packet_wsize_valid_i,
  input  logic [packet_size_width_lp-1:0] packet_wsize_i,
  input  logic                            packet_wvalid_i,
  input  logic [packet_addr_width_lp-1:0] packet_waddr_i,
  input  logic [data_width_p-1:0]         packet_wdata_i,
  input  logic [size_width_lp-1:0]        packet_wdata_size_i,
  input  logic                            tx_interrupt_clear_i,
  input  logic                            tx_interrupt_enable_i,
  input  logic                            tx_interrupt_enable_v_i,
  output logic                            tx_interrupt_pending_o,
  output logic                            tx_interrupt_o,
  output logic [7:0]                      tx_axis_tdata_o,
  output logic                            tx_axis_tvalid_o,
  output logic                            tx_axis_tlast_o,
  input  logic                            tx_axis_tready_i
);

  localparam int unsigned bytes_lp = data_width_p / 8;

  typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

  state_e                          state_q, state_d;
  logic [packet_size_width_lp-1:0] size_q, size_d;
  logic [packet_addr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [packet_addr_width_lp-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [7:0]                      tdata_q, tdata_d;
  logic                            tvalid_q, tvalid_d;
  logic                            tlast_q, tlast_d;
  logic                            pending_q, pending_d;
  logic                            enable_q, enable_d;
  logic                            pending_set;

  logic [7:0]                      mem_q [eth_mtu_p];
  logic [7:0]                      ram_rdata_q;
  logic                            rd_en;
  logic [packet_addr_width_lp-1:0] raddr;

  logic [bytes_lp-1:0]             wr_be;
  logic [packet_addr_width_lp-1:0] align_mask;
  logic                            wr_en;

  always_comb begin
    wr_be      = '0;
    align_mask = '0;
    unique case (packet_wdata_size_i)
      2'd0:    wr_be = 4'b0001;
      2'd1:    begin wr_be = 4'b0011; align_mask = packet_addr_width_lp'(1); end
      2'd2:    begin wr_be = 4'b1111; align_mask = packet_addr_width_lp'(3); end
      default: wr_be = '0;
    endcase
    // Misaligned or size-3 writes are dropped whole; wr_be stays zero for size 3.
    wr_en = (state_q == StIdle) && packet_wvalid_i && (wr_be != '0) &&
            ((packet_waddr_i & align_mask) == '0);
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < bytes_lp; k++) begin
        if (wr_be[k]) mem_q[packet_waddr_i + packet_addr_width_lp'(k)] <= packet_wdata_i[8*k +: 8];
      end
    end
    if (rd_en) ram_rdata_q <= mem_q[raddr];
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_ptr_d = fetch_ptr_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    enable_d    = tx_interrupt_enable_v_i ? tx_interrupt_enable_i : enable_q;
    pending_set = 1'b0;
    rd_en       = 1'b0;
    raddr       = fetch_ptr_q;

    if (state_q == StIdle && packet_wsize_valid_i) begin
      size_d = (packet_wsize_i > packet_size_width_lp'(eth_mtu_p)) ?
               packet_size_width_lp'(eth_mtu_p) : packet_wsize_i;
    end

    // ram_rdata_q always runs one byte ahead of tdata_q once streaming.
    unique case (state_q)
      StIdle: begin
        if (packet_send_i) begin
          if (size_q == '0) begin
            pending_set = 1'b1;
          end else begin
            rd_en       = 1'b1;
            raddr       = '0;
            rd_ptr_d    = '0;
            fetch_ptr_d = packet_addr_width_lp'(1);
            state_d     = StFetch;
          end
        end
      end
      StFetch: begin
        rd_en       = 1'b1;
        fetch_ptr_d = fetch_ptr_q + packet_addr_width_lp'(1);
        tdata_d     = ram_rdata_q;
        tvalid_d    = 1'b1;
        tlast_d     = (size_q == packet_size_width_lp'(1));
        state_d     = StStream;
      end
      StStream: begin
        if (tvalid_q && tx_axis_tready_i) begin
          if (tlast_q) begin
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            pending_set = 1'b1;
            state_d     = StIdle;
          end else begin
            rd_en       = 1'b1;
            fetch_ptr_d = fetch_ptr_q + packet_addr_width_lp'(1);
            rd_ptr_d    = rd_ptr_q + packet_addr_width_lp'(1);
            tdata_d     = ram_rdata_q;
            tlast_d     = (packet_size_width_lp'(rd_ptr_q) + packet_size_width_lp'(2)) == size_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pending_d = pending_set ? 1'b1 : (tx_interrupt_clear_i ? 1'b0 : pending_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      size_q      <= '0;
      rd_ptr_q    <= '0;
      fetch_ptr_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      pending_q   <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
    end
  end

  assign packet_req_o           = (state_q == StIdle);
  assign tx_interrupt_pending_o = pending_q;
  assign tx_interrupt_o         = pending_q & enable_q;
  assign tx_axis_tdata_o        = tdata_q;
  assign tx_axis_tvalid_o       = tvalid_q;
  assign tx_axis_tlast_o        = tlast_q;

endmodule
